mips_pc_sequencer: RTL and testbench
====================================

# mips_pc_sequencer

Parametrised program-counter sequencer feeding `mips_core`. It generates the instruction address stream that benches drive by hand today, and adds what they lack: run and single-step modes, a valid/ready handshake with the core, branch and jump redirection, end-of-program halt or wrap, and a retired-instruction counter. It sits between the bench or control logic and the core's `program_counter` input.

## Interface
- `PC_WIDTH`, 8: address width; all PC arithmetic is modulo 2^PC_WIDTH.
- `START_ADDR`, 0: PC value after reset and on restart.
- `END_ADDR`, 14: last program address.
- `WRAP`, 0: at `END_ADDR`, 1 = loop to `START_ADDR`, 0 = halt.
- `COUNT_WIDTH`, 16: width of the retired-instruction counter.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  pulse; leaves IDLE or HALT.
- `step_mode`  in  1  sampled with `start`: 1 = single-step, 0 = free run.
- `step`  in  1  pulse; issues one instruction in step mode.
- `core_ready`  in  1  core accepts the current PC.
- `branch_taken`  in  1  qualifies `branch_offset` on a retire.
- `branch_offset`  in  PC_WIDTH  signed word offset.
- `jump`  in  1  qualifies `jump_target` on a retire.
- `jump_target`  in  PC_WIDTH  absolute target.
- `halt_req`  in  1  stop request.
- `program_counter`  out  PC_WIDTH  current instruction address (registered).
- `pc_valid`  out  1  `program_counter` is offered to the core.
- `halted`  out  1  sequencer is in HALT.
- `instr_count`  out  COUNT_WIDTH  number of retired instructions (saturating).

## Operation
- States: IDLE, RUN, STEP_WAIT, STEP_ISSUE, HALT.
- Reset, from any state: IDLE, `program_counter` = START_ADDR, `pc_valid` = 0, `halted` = 0, `instr_count` = 0.
- IDLE with `start`: go to RUN if `step_mode` = 0, otherwise STEP_WAIT.
- HALT with `start`: `program_counter` = START_ADDR, `instr_count` = 0, then go to RUN or STEP_WAIT as from IDLE.
- `pc_valid` = 1 only in RUN and STEP_ISSUE. `halted` = 1 only in HALT.
- Retire = `pc_valid` & `core_ready` in a cycle. `branch_taken`, `jump` and `halt_req` matter only in a retire cycle, except `halt_req`, which also acts while stalled or in STEP_WAIT.
- Next PC on retire, in priority order:
  - `jump` → `jump_target`.
  - `branch_taken` → PC + 1 + sign-extended `branch_offset`, truncated to PC_WIDTH.
  - retired PC == END_ADDR → START_ADDR if WRAP = 1; if WRAP = 0, PC is unchanged and the state goes to HALT.
  - otherwise → PC + 1, wrapping at 2^PC_WIDTH.
- `instr_count` increments on every retire and saturates at all-ones.
- In STEP_WAIT, `step` moves to STEP_ISSUE. A retire in STEP_ISSUE returns to STEP_WAIT (or HALT). `step` pulses outside STEP_WAIT are ignored.
- `halt_req` goes to HALT on the next edge. If it coincides with a retire, the retire completes first (PC and count update), then HALT.
- `start` and `step` are ignored while in RUN or STEP_ISSUE.

## Timing
- All outputs are registered.
- `pc_valid` rises one cycle after `start` is sampled (RUN) or after `step` is sampled (STEP_ISSUE).
- RUN with `core_ready` held at 1 gives one retire per cycle with no bubbles. The new PC is visible the cycle after the retire.
- While `core_ready` = 0 in RUN or STEP_ISSUE, `program_counter` and `pc_valid` hold stable.
- Step mode: at most one retire per `step`. Minimum `step`-to-retire latency is 1 cycle.
- `halted` asserts the cycle after the halting edge condition, and `pc_valid` drops the same cycle.
- Asserting `reset` mid-run clears all outputs immediately, without waiting for a clock edge.

## Test plan
- Reset, `start`, `step_mode` = 0, `core_ready` = 1, defaults → PC steps 0, 1, …, 14, one per cycle. After that, `halted` = 1, `pc_valid` = 0, `instr_count` = 15, PC stays at 14.
- WRAP = 1, run 17 retires → PC sequence 0..14, 0, 1. `halted` never asserts.
- At PC = 3, `branch_taken` = 1, offset = −2 → next PC = 2. At PC = 5, `jump` = 1 and `branch_taken` = 1, target 0x0A → next PC = 0x0A (jump wins). PC_WIDTH = 8, PC = 0xFE, offset = +1 → next PC = 0x00.
- Step mode, three `step` pulses spaced 5 cycles apart → exactly three retires (PC 0→1→2→3), `pc_valid` low between them. An extra `step` during STEP_ISSUE is ignored.
- `core_ready` low for 4 cycles at PC = 6 → PC and `pc_valid` hold at 6 with no count change. `halt_req` together with a retire at PC = 6 → PC becomes 7, count increments, then HALT.
- `reset` pulsed mid-run at PC = 9 → immediate PC = 0, `instr_count` = 0, IDLE. Then `start` from HALT restarts at 0 with the count cleared.

Source files
------------

// File: rtl/mips_pc_sequencer.sv
// Program-counter sequencer for mips_core: run / single-step issue, valid/ready
// handshake, branch/jump redirection, end-of-program halt or wrap, retire count.
module mips_pc_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int START_ADDR  = 0,
  parameter int END_ADDR    = 14,
  parameter bit WRAP        = 1'b0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   step_mode,
  input  logic                   step,
  input  logic                   core_ready,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_offset,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jump_target,
  input  logic                   halt_req,
  output logic [PC_WIDTH-1:0]    program_counter,
  output logic                   pc_valid,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [PC_WIDTH-1:0]    START_PC  = PC_WIDTH'(START_ADDR);
  localparam logic [PC_WIDTH-1:0]    END_PC    = PC_WIDTH'(END_ADDR);
  localparam logic [PC_WIDTH-1:0]    PC_ONE    = PC_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP_WAIT,
    STEP_ISSUE,
    HALT
  } state_t;

  state_t                   state;
  state_t                   next_state;
  logic [PC_WIDTH-1:0]      pc;
  logic [PC_WIDTH-1:0]      next_pc;
  logic [COUNT_WIDTH-1:0]   count;
  logic [COUNT_WIDTH-1:0]   next_count;
  logic                     valid_q;
  logic                     halted_q;
  logic                     retire;
  logic                     end_halt;
  logic [PC_WIDTH-1:0]      seq_pc;
  logic [PC_WIDTH-1:0]      branch_pc;

  assign retire = valid_q & core_ready;
  assign seq_pc = pc + PC_ONE;
  // Offset is already PC_WIDTH wide, so modulo addition performs the sign extension.
  assign branch_pc = pc + PC_ONE + branch_offset;

  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_count = count;
    end_halt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = step_mode ? STEP_WAIT : RUN;
        end
      end
      HALT: begin
        if (start) begin
          next_pc    = START_PC;
          next_count = '0;
          next_state = step_mode ? STEP_WAIT : RUN;
        end
      end
      STEP_WAIT: begin
        if (halt_req) begin
          next_state = HALT;
        end else if (step) begin
          next_state = STEP_ISSUE;
        end
      end
      RUN, STEP_ISSUE: begin
        if (retire) begin
          if (count != '1) begin
            next_count = count + COUNT_ONE;
          end
          if (jump) begin
            next_pc = jump_target;
          end else if (branch_taken) begin
            next_pc = branch_pc;
          end else if (pc == END_PC) begin
            if (WRAP) begin
              next_pc = START_PC;
            end else begin
              end_halt = 1'b1;
            end
          end else begin
            next_pc = seq_pc;
          end
          // The retire always completes before a halt takes effect.
          if (end_halt || halt_req) begin
            next_state = HALT;
          end else if (state == STEP_ISSUE) begin
            next_state = STEP_WAIT;
          end
        end else if (halt_req) begin
          next_state = HALT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they change with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= START_PC;
      count    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= next_state;
      pc       <= next_pc;
      count    <= next_count;
      valid_q  <= (next_state == RUN) || (next_state == STEP_ISSUE);
      halted_q <= (next_state == HALT);
    end
  end

  assign program_counter = pc;
  assign pc_valid        = valid_q;
  assign halted          = halted_q;
  assign instr_count     = count;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed bench for mips_pc_sequencer: a vector table for redirection and
// handshake cases plus hand-written run, wrap, step, stall and reset sequences.
module tb_mips_pc_sequencer;

  logic       clock;
  logic       reset;
  logic       start;
  logic       step_mode;
  logic       step;
  logic       core_ready;
  logic       branch_taken;
  logic [7:0] branch_offset;
  logic       jump;
  logic [7:0] jump_target;
  logic       halt_req;

  logic [7:0]  pc;
  logic        valid;
  logic        halted;
  logic [15:0] count;
  logic [7:0]  wrap_pc;
  logic        wrap_valid;
  logic        wrap_halted;
  logic [15:0] wrap_count;
  logic [7:0]  sat_pc;
  logic        sat_valid;
  logic        sat_halted;
  logic [1:0]  sat_count;

  int compared;
  int mismatched;

  mips_pc_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .step_mode(step_mode),
    .step(step), .core_ready(core_ready), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .halt_req(halt_req), .program_counter(pc), .pc_valid(valid),
    .halted(halted), .instr_count(count)
  );

  mips_pc_sequencer #(.WRAP(1'b1)) dut_wrap (
    .clock(clock), .reset(reset), .start(start), .step_mode(step_mode),
    .step(step), .core_ready(core_ready), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .halt_req(halt_req), .program_counter(wrap_pc), .pc_valid(wrap_valid),
    .halted(wrap_halted), .instr_count(wrap_count)
  );

  mips_pc_sequencer #(.WRAP(1'b1), .COUNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .step_mode(step_mode),
    .step(step), .core_ready(core_ready), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .halt_req(halt_req), .program_counter(sat_pc), .pc_valid(sat_valid),
    .halted(sat_halted), .instr_count(sat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       start;
    logic       core_ready;
    logic       branch_taken;
    logic [7:0] branch_offset;
    logic       jump;
    logic [7:0] jump_target;
    logic       halt_req;
    logic [7:0] exp_pc;
    logic       exp_valid;
    logic       exp_halted;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t make_vec(input logic st, input logic rdy, input logic br,
                                    input logic [7:0] off, input logic j,
                                    input logic [7:0] tgt, input logic hr,
                                    input logic [7:0] epc, input logic ev,
                                    input logic eh, input logic [15:0] ec);
    vec_t v;
    v.start = st; v.core_ready = rdy; v.branch_taken = br; v.branch_offset = off;
    v.jump = j; v.jump_target = tgt; v.halt_req = hr;
    v.exp_pc = epc; v.exp_valid = ev; v.exp_halted = eh; v.exp_count = ec;
    return v;
  endfunction

  task automatic compare(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_output(input string name, input int exp_pc, input int exp_valid,
                              input int exp_halted, input int exp_count);
    compare({name, " pc"}, 32'(pc), exp_pc);
    compare({name, " valid"}, 32'(valid), exp_valid);
    compare({name, " halted"}, 32'(halted), exp_halted);
    compare({name, " count"}, 32'(count), exp_count);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; step_mode = 0; step = 0; core_ready = 0; branch_taken = 0;
    branch_offset = 8'h00; jump = 0; jump_target = 8'h00; halt_req = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    #3;
    check_output("reset", 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic apply_stimulus(input vec_t v);
    start = v.start; core_ready = v.core_ready; branch_taken = v.branch_taken;
    branch_offset = v.branch_offset; jump = v.jump; jump_target = v.jump_target;
    halt_req = v.halt_req; step = 1'b0; step_mode = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    clear_inputs();

    //                  st rdy br off    j  tgt    hr  pc     v  h  cnt
    vecs[0]  = make_vec(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    vecs[1]  = make_vec(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h01, 1, 0, 1);
    vecs[2]  = make_vec(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h02, 1, 0, 2);
    vecs[3]  = make_vec(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h03, 1, 0, 3);
    vecs[4]  = make_vec(0, 1, 1, 8'hFE, 0, 8'h00, 0, 8'h02, 1, 0, 4);
    vecs[5]  = make_vec(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h03, 1, 0, 5);
    vecs[6]  = make_vec(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h04, 1, 0, 6);
    vecs[7]  = make_vec(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h05, 1, 0, 7);
    vecs[8]  = make_vec(0, 1, 1, 8'hFE, 1, 8'h0A, 0, 8'h0A, 1, 0, 8);
    vecs[9]  = make_vec(0, 1, 0, 8'h00, 1, 8'hFE, 0, 8'hFE, 1, 0, 9);
    vecs[10] = make_vec(0, 1, 1, 8'h01, 0, 8'h00, 0, 8'h00, 1, 0, 10);
    vecs[11] = make_vec(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 10);
    vecs[12] = make_vec(0, 0, 1, 8'h05, 1, 8'h20, 0, 8'h00, 1, 0, 10);
    vecs[13] = make_vec(0, 1, 0, 8'h00, 1, 8'h0E, 0, 8'h0E, 1, 0, 11);
    vecs[14] = make_vec(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h0E, 0, 1, 12);
    vecs[15] = make_vec(0, 1, 1, 8'h03, 0, 8'h00, 0, 8'h0E, 0, 1, 12);
    vecs[16] = make_vec(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    vecs[17] = make_vec(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 0, 1, 0);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i]);
      tick();
      check_output($sformatf("vec%0d", i), int'(vecs[i].exp_pc), int'(vecs[i].exp_valid),
                   int'(vecs[i].exp_halted), int'(vecs[i].exp_count));
    end

    // Free run to the end of program: halt (default), wrap, saturating count.
    do_reset();
    start = 1; core_ready = 1;
    tick();
    start = 0;
    check_output("run start", 0, 1, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k <= 14) check_output($sformatf("run r%0d", k), k, 1, 0, k);
      else         check_output($sformatf("run end r%0d", k), 14, 0, 1, 15);
      compare($sformatf("wrap pc r%0d", k), 32'(wrap_pc), k % 15);
      compare($sformatf("wrap halted r%0d", k), 32'(wrap_halted), 0);
      compare($sformatf("sat count r%0d", k), 32'(sat_count), (k < 3) ? k : 3);
    end

    // Single-step mode with ignored extra steps.
    do_reset();
    start = 1; step_mode = 1; core_ready = 1;
    tick();
    start = 0; step_mode = 0;
    check_output("step wait", 0, 0, 0, 0);
    repeat (4) tick();
    check_output("step idle wait", 0, 0, 0, 0);
    step = 1;
    tick();
    check_output("step1 issue", 0, 1, 0, 0);
    tick();
    step = 0;
    check_output("step1 retire", 1, 0, 0, 1);
    repeat (4) tick();
    check_output("step1 gap", 1, 0, 0, 1);
    core_ready = 0; step = 1;
    tick();
    step = 0;
    check_output("step2 issue", 1, 1, 0, 1);
    step = 1;
    tick();
    step = 0; core_ready = 1;
    check_output("step2 stalled", 1, 1, 0, 1);
    tick();
    check_output("step2 retire", 2, 0, 0, 2);
    repeat (4) tick();
    check_output("step2 gap", 2, 0, 0, 2);
    step = 1;
    tick();
    step = 0;
    check_output("step3 issue", 2, 1, 0, 2);
    tick();
    check_output("step3 retire", 3, 0, 0, 3);
    repeat (4) tick();
    check_output("step3 gap", 3, 0, 0, 3);
    halt_req = 1;
    tick();
    halt_req = 0;
    check_output("step halt", 3, 0, 1, 3);

    // Stall then halt request coinciding with a retire.
    do_reset();
    start = 1; core_ready = 1;
    tick();
    start = 0;
    repeat (6) tick();
    check_output("stall reach6", 6, 1, 0, 6);
    core_ready = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output($sformatf("stall c%0d", k), 6, 1, 0, 6);
    end
    core_ready = 1; halt_req = 1;
    tick();
    halt_req = 0;
    check_output("halt on retire", 7, 0, 1, 7);
    tick();
    check_output("halt hold", 7, 0, 1, 7);

    // Asynchronous reset mid-run, then restart from HALT.
    do_reset();
    start = 1; core_ready = 1;
    tick();
    start = 0;
    repeat (9) tick();
    check_output("pre-reset", 9, 1, 0, 9);
    #2;
    reset = 1;
    #1;
    check_output("async reset", 0, 0, 0, 0);
    #1;
    reset = 0;
    tick();
    check_output("idle after reset", 0, 0, 0, 0);
    start = 1;
    tick();
    start = 0;
    repeat (2) tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    check_output("halt before restart", 3, 0, 1, 3);
    start = 1;
    tick();
    start = 0;
    check_output("restart", 0, 1, 0, 0);
    tick();
    check_output("restart retire", 1, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
